// File: rtl/period_meter_if.sv
// Signal bundle between a period meter and whatever consumes its results.
// The meter (master) samples sig_in and drives the measurement outputs;
// the consumer (slave) supplies sig_in and observes the results.
interface period_meter_if #(
    parameter int unsigned CNT_W = 32
);
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    modport master (
        input  sig_in,
        output period,
        output high_time,
        output meas_valid,
        output locked,
        output timeout
    );

    modport slave (
        output sig_in,
        input  period,
        input  high_time,
        input  meas_valid,
        input  locked,
        input  timeout
    );
endinterface

// File: rtl/period_meter.sv
// Period / high-time meter for a slow asynchronous square wave, counted in
// inclk cycles. It flags loss of signal, and it asserts a lock flag once the
// period has stayed near the expected value for several periods in a row.
module period_meter #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned EXPECTED = 100000002,
    parameter int unsigned TOL      = 2,
    parameter int unsigned LOCK_N   = 4,
    parameter int unsigned TIMEOUT  = 200000000
) (
    input  logic           inclk,
    input  logic           reset,
    period_meter_if.master mon
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    // Tolerance window is computed one bit wider so EXPECTED+TOL cannot wrap;
    // the lower bound clamps at zero when TOL exceeds EXPECTED.
    localparam logic [CNT_W:0]   LO_BOUND  = (TOL > EXPECTED) ? (CNT_W+1)'(0)
                                                              : (CNT_W+1)'(EXPECTED - TOL);
    localparam logic [CNT_W:0]   HI_BOUND  = (CNT_W+1)'(EXPECTED) + (CNT_W+1)'(TOL);
    localparam logic [3:0]       LOCK_N_C  = 4'(LOCK_N);

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       lock_cnt_q, lock_cnt_d;

    logic             edge_pulse;
    logic             in_tol;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hcnt_inc;
    logic [3:0]       lock_cnt_inc;

    // Next-state, counter and result logic; the edge pulse always wins over
    // a timeout in the same cycle so a period of exactly TIMEOUT still measures.
    always_comb begin
        s1_d         = mon.sig_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        hcnt_d       = hcnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        lock_cnt_d   = lock_cnt_q;

        edge_pulse   = s2_q & ~s3_q;
        cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        hcnt_inc     = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + CNT_ONE;
        in_tol       = ({1'b0, cnt_q} >= LO_BOUND) && ({1'b0, cnt_q} <= HI_BOUND);
        lock_cnt_inc = (lock_cnt_q >= LOCK_N_C) ? LOCK_N_C : lock_cnt_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (edge_pulse) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                    hcnt_d  = CNT_ONE;
                end else if (cnt_q >= TIMEOUT_C) begin
                    state_d    = LOST;
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    lock_cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            MEASURE: begin
                if (edge_pulse) begin
                    period_d     = cnt_q;
                    high_time_d  = hcnt_q;
                    meas_valid_d = 1'b1;
                    cnt_d        = CNT_ONE;
                    hcnt_d       = CNT_ONE;
                    if (in_tol) begin
                        lock_cnt_d = lock_cnt_inc;
                        locked_d   = (lock_cnt_inc == LOCK_N_C);
                    end else begin
                        lock_cnt_d = 4'd0;
                        locked_d   = 1'b0;
                    end
                end else if (cnt_q >= TIMEOUT_C) begin
                    state_d    = LOST;
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    lock_cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_inc;
                    if (s2_q) begin
                        hcnt_d = hcnt_inc;
                    end
                end
            end
            LOST: begin
                if (edge_pulse) begin
                    state_d   = MEASURE;
                    cnt_d     = CNT_ONE;
                    hcnt_d    = CNT_ONE;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, synchroniser chain and registered outputs.
    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            lock_cnt_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    assign mon.period     = period_q;
    assign mon.high_time  = high_time_q;
    assign mon.meas_valid = meas_valid_q;
    assign mon.locked     = locked_q;
    assign mon.timeout    = timeout_q;
endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: waveforms of hand-chosen period and duty,
// with every reported measurement compared against a table of expected values.
module tb_period_meter;
    localparam int unsigned CNT_W = 32;
    localparam int NUM_MEAS = 27;

    logic inclk = 1'b0;
    logic reset;
    int   cycle_cnt = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    period_meter_if #(.CNT_W(CNT_W)) pm_if ();

    period_meter #(
        .CNT_W   (CNT_W),
        .EXPECTED(10),
        .TOL     (1),
        .LOCK_N  (4),
        .TIMEOUT (50)
    ) dut (
        .inclk(inclk),
        .reset(reset),
        .mon  (pm_if)
    );

    // Expected measurement sequence (period, high time, locked, timeout).
    int exp_per  [NUM_MEAS] = '{10,10,10,10,13,10,11, 9,10,13,10,10,10,10,
                                10,10,20,20,20,10,10,10,10,10,10,50,50};
    int exp_high [NUM_MEAS] = '{ 5, 5, 5, 5, 6, 5, 5, 4, 5, 6, 5, 5, 5, 5,
                                 5, 5, 1,10,19, 5, 5, 5, 5, 5, 5,25,25};
    int exp_lock [NUM_MEAS] = '{ 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1,
                                 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    // Waveform table: high and low length of each driven period.
    int seq_high [23] = '{5,5,5,5,6,5,5,4,5,6,5,5,5,5, 5,5, 1,10,19,5,5,5,5};
    int seq_low  [23] = '{5,5,5,5,7,5,6,5,5,7,5,5,5,5, 5,5,19,10, 1,5,5,5,5};

    int unsigned mv_per[$];
    int unsigned mv_high[$];
    int unsigned mv_lock[$];
    int unsigned mv_to[$];
    int          mv_cyc[$];
    int          to_rises = 0;
    int          to_rise_cyc = 0;
    logic        to_prev = 1'b0;

    // Free-running clock.
    always #5 inclk = ~inclk;

    // Cycle counter used to time measurements and the timeout rise.
    always @(posedge inclk) cycle_cnt <= cycle_cnt + 1;

    // Record every measurement pulse and every rising edge of timeout.
    always @(negedge inclk) begin
        if (pm_if.meas_valid === 1'b1) begin
            mv_per.push_back(pm_if.period);
            mv_high.push_back(pm_if.high_time);
            mv_lock.push_back({31'd0, pm_if.locked});
            mv_to.push_back({31'd0, pm_if.timeout});
            mv_cyc.push_back(cycle_cnt);
        end
        if (pm_if.timeout === 1'b1 && to_prev == 1'b0) begin
            to_rises++;
            to_rise_cyc = cycle_cnt;
        end
        to_prev = (pm_if.timeout === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one period starting with a rising edge; entered and left #1 after a posedge.
    task automatic applyStimulus(input int high_len, input int low_len);
        pm_if.sig_in = 1'b1;
        repeat (high_len) @(posedge inclk);
        #1 pm_if.sig_in = 1'b0;
        repeat (low_len) @(posedge inclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, ".period"},     pm_if.period, 0);
        checkOutput({tag, ".high_time"},  pm_if.high_time, 0);
        checkOutput({tag, ".meas_valid"}, {31'd0, pm_if.meas_valid}, 0);
        checkOutput({tag, ".locked"},     {31'd0, pm_if.locked}, 0);
        checkOutput({tag, ".timeout"},    {31'd0, pm_if.timeout}, 0);
    endtask

    initial begin
        int waited;
        int last;
        reset = 1'b1;
        pm_if.sig_in = 1'b0;
        repeat (3) @(posedge inclk);
        @(negedge inclk);
        check_all_zero("reset");
        @(posedge inclk);
        #1 reset = 1'b0;

        // Basic 10-cycle wave, then out-of-tolerance and relock patterns.
        for (int i = 0; i < 14; i++) applyStimulus(seq_high[i], seq_low[i]);
        for (int i = 1; i < 4; i++) begin
            checkOutput($sformatf("interval%0d", i),
                        (mv_cyc.size() > i) ? mv_cyc[i] - mv_cyc[i-1] : -1, 10);
        end

        // Final rising edge, then the input goes quiet.
        pm_if.sig_in = 1'b1;
        repeat (5) @(posedge inclk);
        #1 pm_if.sig_in = 1'b0;
        waited = 0;
        while (to_rises == 0 && waited < 200) begin
            @(posedge inclk);
            waited++;
        end
        #1;
        checkOutput("timeout_seen", to_rises, 1);
        last = mv_cyc.size() - 1;
        checkOutput("timeout_delay", (last >= 0) ? to_rise_cyc - mv_cyc[last] : -1, 50);
        checkOutput("lost_mv_count", mv_per.size(), 14);
        checkOutput("lost.timeout",   {31'd0, pm_if.timeout}, 1);
        checkOutput("lost.locked",    {31'd0, pm_if.locked}, 0);
        checkOutput("lost.period",    pm_if.period, 10);
        checkOutput("lost.high_time", pm_if.high_time, 5);

        // Restart: the first edge only clears timeout.
        applyStimulus(seq_high[14], seq_low[14]);
        checkOutput("restart.timeout", {31'd0, pm_if.timeout}, 0);
        checkOutput("restart_mv_count", mv_per.size(), 14);
        for (int i = 15; i < 23; i++) applyStimulus(seq_high[i], seq_low[i]);

        // One-cycle reset in the low phase of a period while locked.
        pm_if.sig_in = 1'b1;
        repeat (5) @(posedge inclk);
        #1 pm_if.sig_in = 1'b0;
        repeat (2) @(posedge inclk);
        #1 reset = 1'b1;
        @(posedge inclk);
        #1 reset = 1'b0;
        check_all_zero("after_reset");
        checkOutput("pre_reset_mv_count", mv_per.size(), 23);
        repeat (3) @(posedge inclk);
        #1;
        applyStimulus(5, 5);
        checkOutput("one_edge_mv_count", mv_per.size(), 23);
        applyStimulus(5, 5);

        // Periods of exactly TIMEOUT cycles must measure without timing out.
        applyStimulus(25, 25);
        applyStimulus(25, 25);
        applyStimulus(5, 10);
        checkOutput("timeout_rises", to_rises, 1);
        checkOutput("end.timeout", {31'd0, pm_if.timeout}, 0);

        checkOutput("mv_total", mv_per.size(), NUM_MEAS);
        for (int i = 0; i < NUM_MEAS; i++) begin
            checkOutput($sformatf("m%0d.period", i + 1),
                        (i < mv_per.size()) ? mv_per[i] : 32'hFFFF_FFFF, exp_per[i]);
            checkOutput($sformatf("m%0d.high_time", i + 1),
                        (i < mv_high.size()) ? mv_high[i] : 32'hFFFF_FFFF, exp_high[i]);
            checkOutput($sformatf("m%0d.locked", i + 1),
                        (i < mv_lock.size()) ? mv_lock[i] : 32'hFFFF_FFFF, exp_lock[i]);
            checkOutput($sformatf("m%0d.timeout", i + 1),
                        (i < mv_to.size()) ? mv_to[i] : 32'hFFFF_FFFF, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
